// File: rtl/rd_scoreboard_pkg.sv
// rd_scoreboard_pkg
// Shared definitions for the destination-register scoreboard:
//   REG_W    - architectural register index width (16 registers)
//   OP_LW    - decode opcode that identifies a load
//   stage_t  - per-stage record carried through EX, MEM and WB
package rd_scoreboard_pkg;

  localparam int REG_W = 4;
  localparam logic [3:0] OP_LW = 4'b0111;

  typedef struct packed {
    logic             valid;
    logic             wr;
    logic [REG_W-1:0] rd;
    logic             is_load;
  } stage_t;

  localparam stage_t STAGE_EMPTY = '0;

endpackage

// File: rtl/rd_stage_reg.sv
// rd_stage_reg
// One pipeline stage of the destination-register tracker.
// Ports:
//   clk    - pipeline clock
//   reset  - asynchronous active-high reset, clears the record
//   hold   - keep the current record (highest priority)
//   bubble - load an empty record instead of d
//   d      - record arriving from the previous stage
//   q      - record currently held by this stage
module rd_stage_reg
  import rd_scoreboard_pkg::*;
(
  input  logic   clk,
  input  logic   reset,
  input  logic   hold,
  input  logic   bubble,
  input  stage_t d,
  output stage_t q
);

  // hold beats bubble so a frozen pipeline never loses its contents.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      q <= STAGE_EMPTY;
    end else if (hold) begin
      q <= q;
    end else if (bubble) begin
      q <= STAGE_EMPTY;
    end else begin
      q <= d;
    end
  end

endmodule

// File: rtl/rd_scoreboard.sv
// rd_scoreboard
// Tracks each decoded instruction's destination register through EX, MEM
// and WB for the decode-stage forwarding selects, and raises the stall that
// holds PC/decode on a load-use hazard or a data-memory wait.
// Ports:
//   clk, reset                 - clock, asynchronous active-high reset
//   dcd_valid/opcode/wrReg/rd  - instruction currently in decode
//   dcd_rs1, dcd_rs2           - its source register indices
//   flush                      - branch redirect, kills the decode instruction
//   mem_busy                   - data memory not ready, freezes the pipeline
//   wrReg_EX/MEM/WB            - stage holds a valid register write
//   exe_rd, mem_rd, wb_rd      - stage destination indices
//   stall                      - hold PC and decode register this cycle
//   stall_cnt, flush_cnt       - saturating statistics counters
// Build option: define SCOREBOARD_STATS_EN to add the statistics counters.
module rd_scoreboard #(
  parameter int REG_W = rd_scoreboard_pkg::REG_W,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             dcd_valid,
  input  logic [3:0]       dcd_opcode,
  input  logic             dcd_wrReg,
  input  logic [REG_W-1:0] dcd_rd,
  input  logic [REG_W-1:0] dcd_rs1,
  input  logic [REG_W-1:0] dcd_rs2,
  input  logic             flush,
  input  logic             mem_busy,
  output logic             wrReg_EX,
  output logic             wrReg_MEM,
  output logic             wrReg_WB,
  output logic [REG_W-1:0] exe_rd,
  output logic [REG_W-1:0] mem_rd,
  output logic [REG_W-1:0] wb_rd,
`ifdef SCOREBOARD_STATS_EN
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt,
`endif
  output logic             stall
);

  import rd_scoreboard_pkg::*;

  stage_t ex_d;
  stage_t ex_q;
  stage_t mem_q;
  stage_t wb_q;
  logic   load_use;
  logic   ex_bubble;

  always_comb begin
    ex_d         = STAGE_EMPTY;
    ex_d.valid   = dcd_valid;
    ex_d.wr      = dcd_wrReg;
    ex_d.rd      = dcd_rd;
    ex_d.is_load = (dcd_opcode == OP_LW);
  end

  // Register 0 is compared like any other index so the stall agrees with
  // the forwarding selects, which also treat r0 normally.
  assign load_use = dcd_valid & ex_q.valid & ex_q.wr & ex_q.is_load &
                    ((dcd_rs1 == ex_q.rd) | (dcd_rs2 == ex_q.rd));

  assign stall = mem_busy | load_use;

  // A flush and a load-use hazard both need the same EX bubble; mem_busy
  // overrides both inside the stage register via hold.
  assign ex_bubble = flush | load_use;

  rd_stage_reg u_ex (
    .clk    (clk),
    .reset  (reset),
    .hold   (mem_busy),
    .bubble (ex_bubble),
    .d      (ex_d),
    .q      (ex_q)
  );

  rd_stage_reg u_mem (
    .clk    (clk),
    .reset  (reset),
    .hold   (mem_busy),
    .bubble (1'b0),
    .d      (ex_q),
    .q      (mem_q)
  );

  rd_stage_reg u_wb (
    .clk    (clk),
    .reset  (reset),
    .hold   (mem_busy),
    .bubble (1'b0),
    .d      (mem_q),
    .q      (wb_q)
  );

  assign wrReg_EX  = ex_q.valid & ex_q.wr;
  assign wrReg_MEM = mem_q.valid & mem_q.wr;
  assign wrReg_WB  = wb_q.valid & wb_q.wr;
  assign exe_rd    = ex_q.rd;
  assign mem_rd    = mem_q.rd;
  assign wb_rd     = wb_q.rd;

  // The load flag only matters in EX; later copies are carried but unread.
  logic unused_is_load;
  assign unused_is_load = mem_q.is_load ^ wb_q.is_load;

`ifdef SCOREBOARD_STATS_EN
  logic stall_inc;
  logic flush_inc;

  // A stall cycle that coincides with a flush is counted as a flush only.
  assign stall_inc = load_use & ~mem_busy & ~flush;
  assign flush_inc = flush & ~mem_busy;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (stall_inc && (stall_cnt != {CNT_W{1'b1}})) begin
        stall_cnt <= stall_cnt + CNT_W'(1);
      end
      if (flush_inc && (flush_cnt != {CNT_W{1'b1}})) begin
        flush_cnt <= flush_cnt + CNT_W'(1);
      end
    end
  end
`else
  localparam int unused_cnt_w = CNT_W;
`endif

endmodule

// File: tb/tb_rd_scoreboard.sv
// tb_rd_scoreboard
// Directed self-checking bench for rd_scoreboard: reset, pipeline flow,
// load-use stall, memory freeze, flush priority, mid-stream reset and, when
// SCOREBOARD_STATS_EN is defined, the saturating statistics counters
// (bench uses a 4-bit counter width so saturation is reached quickly).
module tb_rd_scoreboard;

  localparam int RW = 4;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic          dcd_valid;
  logic [3:0]    dcd_opcode;
  logic          dcd_wrReg;
  logic [RW-1:0] dcd_rd;
  logic [RW-1:0] dcd_rs1;
  logic [RW-1:0] dcd_rs2;
  logic          flush;
  logic          mem_busy;
  logic          wrReg_EX;
  logic          wrReg_MEM;
  logic          wrReg_WB;
  logic [RW-1:0] exe_rd;
  logic [RW-1:0] mem_rd;
  logic [RW-1:0] wb_rd;
  logic          stall;
`ifdef SCOREBOARD_STATS_EN
  logic [CW-1:0] stall_cnt;
  logic [CW-1:0] flush_cnt;
`endif

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  rd_scoreboard #(.REG_W(RW), .CNT_W(CW)) dut (
    .clk        (clk),
    .reset      (reset),
    .dcd_valid  (dcd_valid),
    .dcd_opcode (dcd_opcode),
    .dcd_wrReg  (dcd_wrReg),
    .dcd_rd     (dcd_rd),
    .dcd_rs1    (dcd_rs1),
    .dcd_rs2    (dcd_rs2),
    .flush      (flush),
    .mem_busy   (mem_busy),
    .wrReg_EX   (wrReg_EX),
    .wrReg_MEM  (wrReg_MEM),
    .wrReg_WB   (wrReg_WB),
    .exe_rd     (exe_rd),
    .mem_rd     (mem_rd),
    .wb_rd      (wb_rd),
`ifdef SCOREBOARD_STATS_EN
    .stall_cnt  (stall_cnt),
    .flush_cnt  (flush_cnt),
`endif
    .stall      (stall)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    dcd_valid  = 1'b0;
    dcd_wrReg  = 1'b0;
    dcd_opcode = 4'd0;
    dcd_rd     = '0;
    dcd_rs1    = '0;
    dcd_rs2    = '0;
    flush      = 1'b0;
    mem_busy   = 1'b0;
  endtask

  task automatic decode(input logic [3:0] op, input logic [RW-1:0] rd,
                        input logic [RW-1:0] rs1, input logic [RW-1:0] rs2);
    dcd_valid  = 1'b1;
    dcd_wrReg  = 1'b1;
    dcd_opcode = op;
    dcd_rd     = rd;
    dcd_rs1    = rs1;
    dcd_rs2    = rs2;
  endtask

  // {wrReg_EX, wrReg_MEM, wrReg_WB, exe_rd, mem_rd, wb_rd, stall}
  function automatic logic [15:0] snap();
    return {wrReg_EX, wrReg_MEM, wrReg_WB, exe_rd, mem_rd, wb_rd, stall};
  endfunction

  task automatic test_reset();
    logic [15:0] exp;
    reset = 1'b1;
    idle();
    mem_busy = 1'b1;
    #1;
    exp = {3'b000, 4'd0, 4'd0, 4'd0, 1'b1};
    total++;
    if (snap() !== exp) begin
      bad++;
      $display("[TB] FAIL reset_busy: got %h expected %h", snap(), exp);
    end
    mem_busy = 1'b0;
    #1;
    exp = 16'h0000;
    total++;
    if (snap() !== exp) begin
      bad++;
      $display("[TB] FAIL reset_idle: got %h expected %h", snap(), exp);
    end
`ifdef SCOREBOARD_STATS_EN
    total++;
    if ({stall_cnt, flush_cnt} !== 8'h00) begin
      bad++;
      $display("[TB] FAIL reset_counters: got %h expected 00", {stall_cnt, flush_cnt});
    end
`endif
    tick();
    tick();
    reset = 1'b0;
    tick();
    total++;
    if (snap() !== exp) begin
      bad++;
      $display("[TB] FAIL reset_release: got %h expected %h", snap(), exp);
    end
  endtask

  task automatic test_flow();
    logic [15:0] exp;
    decode(4'd0, 4'd5, 4'd0, 4'd0);
    tick();
    exp = {3'b100, 4'd5, 4'd0, 4'd0, 1'b0};
    total++;
    if (snap() !== exp) begin
      bad++;
      $display("[TB] FAIL flow_ex: got %h expected %h", snap(), exp);
    end
    idle();
    tick();
    exp = {3'b010, 4'd0, 4'd5, 4'd0, 1'b0};
    total++;
    if (snap() !== exp) begin
      bad++;
      $display("[TB] FAIL flow_mem: got %h expected %h", snap(), exp);
    end
    tick();
    exp = {3'b001, 4'd0, 4'd0, 4'd5, 1'b0};
    total++;
    if (snap() !== exp) begin
      bad++;
      $display("[TB] FAIL flow_wb: got %h expected %h", snap(), exp);
    end
    tick();
    exp = 16'h0000;
    total++;
    if (snap() !== exp) begin
      bad++;
      $display("[TB] FAIL flow_drain: got %h expected %h", snap(), exp);
    end
  endtask

  task automatic test_load_use();
    logic [15:0] exp;
    decode(4'b0111, 4'd3, 4'd0, 4'd0);
    tick();
    exp = {3'b100, 4'd3, 4'd0, 4'd0, 1'b0};
    total++;
    if (snap() !== exp) begin
      bad++;
      $display("[TB] FAIL lu_load_in_ex: got %h expected %h", snap(), exp);
    end
    decode(4'd0, 4'd9, 4'd1, 4'd3);
    #1;
    total++;
    if (stall !== 1'b1) begin
      bad++;
      $display("[TB] FAIL lu_stall: got %b expected 1", stall);
    end
    tick();
    total++;
    if ({wrReg_EX, wrReg_MEM, mem_rd, stall} !== {1'b0, 1'b1, 4'd3, 1'b0}) begin
      bad++;
      $display("[TB] FAIL lu_bubble: got %h expected %h",
               {wrReg_EX, wrReg_MEM, mem_rd, stall}, {1'b0, 1'b1, 4'd3, 1'b0});
    end
    tick();
    total++;
    if ({wrReg_EX, exe_rd, wrReg_MEM, wrReg_WB, wb_rd} !== {1'b1, 4'd9, 1'b0, 1'b1, 4'd3}) begin
      bad++;
      $display("[TB] FAIL lu_resume: got %h expected %h",
               {wrReg_EX, exe_rd, wrReg_MEM, wrReg_WB, wb_rd}, {1'b1, 4'd9, 1'b0, 1'b1, 4'd3});
    end
    idle();
    tick();
    tick();
    tick();
    decode(4'd0, 4'd3, 4'd0, 4'd0);
    tick();
    decode(4'd0, 4'd9, 4'd1, 4'd3);
    #1;
    total++;
    if (stall !== 1'b0) begin
      bad++;
      $display("[TB] FAIL lu_nonload_stall: got %b expected 0", stall);
    end
    tick();
    exp = {3'b110, 4'd9, 4'd3, 4'd0, 1'b0};
    total++;
    if (snap() !== exp) begin
      bad++;
      $display("[TB] FAIL lu_nonload_flow: got %h expected %h", snap(), exp);
    end
    idle();
    tick();
    tick();
    tick();
  endtask

  task automatic test_freeze();
    logic [15:0] exp;
    decode(4'd0, 4'd5, 4'd0, 4'd0);
    tick();
    decode(4'd0, 4'd6, 4'd0, 4'd0);
    tick();
    decode(4'd0, 4'd7, 4'd0, 4'd0);
    tick();
    decode(4'd0, 4'd8, 4'd0, 4'd0);
    mem_busy = 1'b1;
    #1;
    exp = {3'b111, 4'd7, 4'd6, 4'd5, 1'b1};
    total++;
    if (snap() !== exp) begin
      bad++;
      $display("[TB] FAIL freeze_enter: got %h expected %h", snap(), exp);
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      total++;
      if (snap() !== exp) begin
        bad++;
        $display("[TB] FAIL freeze_hold%0d: got %h expected %h", i, snap(), exp);
      end
    end
    mem_busy = 1'b0;
    #1;
    exp = {3'b111, 4'd7, 4'd6, 4'd5, 1'b0};
    total++;
    if (snap() !== exp) begin
      bad++;
      $display("[TB] FAIL freeze_release: got %h expected %h", snap(), exp);
    end
    tick();
    exp = {3'b111, 4'd8, 4'd7, 4'd6, 1'b0};
    total++;
    if (snap() !== exp) begin
      bad++;
      $display("[TB] FAIL freeze_advance: got %h expected %h", snap(), exp);
    end
    idle();
    tick();
    tick();
    tick();
  endtask

  task automatic test_flush();
    decode(4'b0111, 4'd3, 4'd0, 4'd0);
    tick();
    decode(4'd0, 4'd9, 4'd3, 4'd0);
    flush = 1'b1;
    #1;
    total++;
    if (stall !== 1'b1) begin
      bad++;
      $display("[TB] FAIL flush_lu_stall: got %b expected 1", stall);
    end
    tick();
    total++;
    if ({wrReg_EX, wrReg_MEM, mem_rd} !== {1'b0, 1'b1, 4'd3}) begin
      bad++;
      $display("[TB] FAIL flush_bubble: got %h expected %h",
               {wrReg_EX, wrReg_MEM, mem_rd}, {1'b0, 1'b1, 4'd3});
    end
`ifdef SCOREBOARD_STATS_EN
    total++;
    if ({stall_cnt, flush_cnt} !== {4'd1, 4'd1}) begin
      bad++;
      $display("[TB] FAIL flush_counts: got %h expected 11", {stall_cnt, flush_cnt});
    end
`endif
    flush = 1'b0;
    decode(4'd0, 4'd4, 4'd0, 4'd0);
    tick();
    total++;
    if ({wrReg_EX, exe_rd, wrReg_MEM, wrReg_WB, wb_rd} !== {1'b1, 4'd4, 1'b0, 1'b1, 4'd3}) begin
      bad++;
      $display("[TB] FAIL flush_refill: got %h expected %h",
               {wrReg_EX, exe_rd, wrReg_MEM, wrReg_WB, wb_rd}, {1'b1, 4'd4, 1'b0, 1'b1, 4'd3});
    end
    decode(4'd0, 4'd11, 4'd0, 4'd0);
    flush    = 1'b1;
    mem_busy = 1'b1;
    tick();
    total++;
    if ({wrReg_EX, exe_rd, wrReg_MEM, wrReg_WB, wb_rd} !== {1'b1, 4'd4, 1'b0, 1'b1, 4'd3}) begin
      bad++;
      $display("[TB] FAIL flush_busy_hold: got %h expected %h",
               {wrReg_EX, exe_rd, wrReg_MEM, wrReg_WB, wb_rd}, {1'b1, 4'd4, 1'b0, 1'b1, 4'd3});
    end
`ifdef SCOREBOARD_STATS_EN
    total++;
    if ({stall_cnt, flush_cnt} !== {4'd1, 4'd1}) begin
      bad++;
      $display("[TB] FAIL flush_busy_counts: got %h expected 11", {stall_cnt, flush_cnt});
    end
`endif
    idle();
    tick();
    tick();
    tick();
  endtask

`ifdef SCOREBOARD_STATS_EN
  task automatic test_stats();
    reset = 1'b1;
    #1;
    reset = 1'b0;
    tick();
    total++;
    if ({stall_cnt, flush_cnt} !== 8'h00) begin
      bad++;
      $display("[TB] FAIL stats_clear: got %h expected 00", {stall_cnt, flush_cnt});
    end
    for (int i = 0; i < 17; i++) begin
      decode(4'b0111, 4'd2, 4'd0, 4'd0);
      tick();
      decode(4'd0, 4'd1, 4'd2, 4'd2);
      tick();
      if (i == 14) begin
        total++;
        if (stall_cnt !== 4'd15) begin
          bad++;
          $display("[TB] FAIL stats_reach_max: got %0d expected 15", stall_cnt);
        end
      end
    end
    total++;
    if ({stall_cnt, flush_cnt} !== {4'd15, 4'd0}) begin
      bad++;
      $display("[TB] FAIL stats_saturate: got %h expected f0", {stall_cnt, flush_cnt});
    end
    idle();
    tick();
    tick();
    tick();
  endtask
`endif

  task automatic test_reset_midstream();
    logic [15:0] exp;
    decode(4'd0, 4'd1, 4'd0, 4'd0);
    tick();
    decode(4'd0, 4'd2, 4'd0, 4'd0);
    tick();
    decode(4'd0, 4'd3, 4'd0, 4'd0);
    tick();
    exp = {3'b111, 4'd3, 4'd2, 4'd1, 1'b0};
    total++;
    if (snap() !== exp) begin
      bad++;
      $display("[TB] FAIL mid_fill: got %h expected %h", snap(), exp);
    end
    #2;
    reset = 1'b1;
    #1;
    exp = 16'h0000;
    total++;
    if (snap() !== exp) begin
      bad++;
      $display("[TB] FAIL mid_reset_async: got %h expected %h", snap(), exp);
    end
`ifdef SCOREBOARD_STATS_EN
    total++;
    if ({stall_cnt, flush_cnt} !== 8'h00) begin
      bad++;
      $display("[TB] FAIL mid_reset_counters: got %h expected 00", {stall_cnt, flush_cnt});
    end
`endif
    tick();
    reset = 1'b0;
    idle();
    tick();
  endtask

  initial begin
    test_reset();
    test_flow();
    test_load_use();
    test_freeze();
    test_flush();
`ifdef SCOREBOARD_STATS_EN
    test_stats();
`endif
    test_reset_midstream();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
